// File: rtl/anim_stepper_if.sv
// Animation-speed interface between the switch-mode selector (master) and
// the animation stepper (slave).
interface anim_stepper_if #(
  parameter int CNT_W = 27,
  parameter int LED_W = 8,
  parameter int POS_W = 3
);
  logic [CNT_W-1:0] tm_value;
  logic             count_en;
  logic             tick;
  logic [POS_W-1:0] pos;
  logic             dir;
  logic [LED_W-1:0] led;

  // Selector side: supplies the period and enable, observes the pattern.
  modport master (
    output tm_value, count_en,
    input  tick, pos, dir, led
  );

  // Stepper side: consumes the period and enable, produces the pattern.
  modport slave (
    input  tm_value, count_en,
    output tick, pos, dir, led
  );
endinterface

// File: rtl/anim_stepper.sv
// Animation stepper: emits a one-cycle tick every tm_value clocks and walks a
// one-hot LED pattern back and forth (ping-pong) on each tick.
module anim_stepper #(
  parameter int CNT_W = 27,
  parameter int LED_W = 8,
  parameter int POS_W = 3
) (
  input  logic           clk,
  input  logic           rst,
  anim_stepper_if.slave  bus
);

  localparam logic [POS_W-1:0] POS_LAST = POS_W'(LED_W - 1);
  localparam logic [POS_W-1:0] POS_TURN = POS_W'(LED_W - 2);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] tm_q, tm_d;
  logic             tick_q, tick_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             dir_q, dir_d;
  logic [LED_W-1:0] led_q, led_d;

  // Terminal count for the current period; unsigned wrap at 0 is harmless
  // because the tm_value == 0 case is caught before this is used.
  logic [CNT_W-1:0] tm_last;
  assign tm_last = bus.tm_value - CNT_W'(1);

  // Next-state: period reload, pause, terminal count with pattern step, count.
  always_comb begin
    // NOTE: every signal gets a default here so no path leaves it unassigned;
    // a missing default would infer a latch.
    cnt_d  = cnt_q;
    tm_d   = tm_q;
    tick_d = 1'b0;
    pos_d  = pos_q;
    dir_d  = dir_q;

    if (bus.tm_value != tm_q) begin
      // A new period restarts the count; never ticks on the change edge.
      tm_d  = bus.tm_value;
      cnt_d = '0;
    end else if (!bus.count_en || bus.tm_value == '0) begin
      // Pause: discard the count, hold the pattern where it is.
      cnt_d = '0;
    end else if (cnt_q == tm_last) begin
      cnt_d  = '0;
      tick_d = 1'b1;
      if (!dir_q) begin
        if (pos_q == POS_LAST) begin
          dir_d = 1'b1;
          pos_d = POS_TURN;
        end else begin
          pos_d = pos_q + POS_W'(1);
        end
      end else begin
        if (pos_q == '0) begin
          dir_d = 1'b0;
          pos_d = POS_W'(1);
        end else begin
          pos_d = pos_q - POS_W'(1);
        end
      end
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    led_d = LED_W'(1) << pos_d;
  end

  // State registers with immediate clear on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      tm_q   <= '0;
      tick_q <= 1'b0;
      pos_q  <= '0;
      dir_q  <= 1'b0;
      led_q  <= LED_W'(1);
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      cnt_q  <= cnt_d;
      tm_q   <= tm_d;
      tick_q <= tick_d;
      pos_q  <= pos_d;
      dir_q  <= dir_d;
      led_q  <= led_d;
    end
  end

  assign bus.tick = tick_q;
  assign bus.pos  = pos_q;
  assign bus.dir  = dir_q;
  assign bus.led  = led_q;

endmodule

// File: doc/anim_stepper.md
# anim_stepper

Consumer side of the animation-speed interface. Takes the period value and enable produced by the switch-mode selector, generates a one-cycle step tick every `tm_value` clocks, and advances a ping-pong one-hot LED pattern on each tick. Sits between the switch-mode selector and the LED display driver.

## Interface
- `CNT_W`, 27: width of period input and internal cycle counter.
- `LED_W`, 8: number of LEDs in the pattern (≥2).
- `POS_W`, 3: width of position output, `ceil(log2(LED_W))`.

- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `tm_value`  in  CNT_W  step period in clock cycles; 0 = stopped.
- `count_en`  in  1  animation enable.
- `tick`  out  1  one-cycle pulse when the pattern advances.
- `pos`  out  POS_W  current lit-LED index.
- `dir`  out  1  travel direction: 0 = toward LED_W-1, 1 = toward 0.
- `led`  out  LED_W  one-hot pattern, `led[pos]` = 1.

## Operation
- Registers: `cnt` (CNT_W), `tm_q` (CNT_W, last sampled period), `tick`, `pos`, `dir`, `led`.
- Reset (async, immediate): `cnt`=0, `tm_q`=0, `tick`=0, `pos`=0, `dir`=0, `led`=1 (bit 0 set).
- Per-edge priority, highest first:
  1. `tm_value != tm_q`: `tm_q`<=`tm_value`, `cnt`<=0, `tick`<=0. The position is unchanged. A period change always restarts the count and never produces a tick in the same cycle.
  2. `count_en`=0 or `tm_value`=0: `cnt`<=0, `tick`<=0. `pos`, `dir`, and `led` hold (pause, not reset).
  3. `cnt == tm_value-1`: `cnt`<=0, `tick`<=1, step the pattern.
  4. Otherwise: `cnt`<=`cnt`+1, `tick`<=0.
- Pattern step (ping-pong, no end repeats):
  - `dir`=0, `pos`<LED_W-1: `pos`+1.
  - `dir`=0, `pos`=LED_W-1: `dir`<=1, `pos`<=LED_W-2.
  - `dir`=1, `pos`>0: `pos`-1.
  - `dir`=1, `pos`=0: `dir`<=0, `pos`<=1.
- `led` is registered and updated on the same edge as `pos`. It is always one-hot of the new `pos`.
- Counter arithmetic: the comparison is unsigned at CNT_W bits. `cnt` never exceeds `tm_value-1`, so there is no overflow path. `tm_value` up to 2^CNT_W-1 is supported.

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs.
- Steady state with `count_en`=1 and constant `tm_value`=N≥1: `tick` is high for exactly 1 cycle in every N. `pos` and `led` change on the same edge that raises `tick`.
- N=1: `tick` is held high continuously. The pattern advances every cycle.
- First tick after enable, or after a period change, with N already stable in `tm_q`: `tick` rises after the N-th enabled edge.
- Period change costs one extra cycle: the change edge itself only reloads `tm_q`. The first tick follows N edges after that.
- Pause/resume: while `count_en`=0 the count is discarded. On re-enable, timing restarts from `cnt`=0 and the pattern continues from the held `pos`/`dir`.
- `rst` asserted mid-count clears everything immediately. After release, the first tick arrives N+1 edges later, including the `tm_q` reload edge.

## Test plan
- Reset: assert `rst` asynchronously between edges -> `tick`=0, `pos`=0, `dir`=0, `led`=8'h01 without waiting for a clock edge.
- Period N=4, `count_en`=1 from reset release -> first `tick` after edge 5 (1 reload edge + 4), then every 4 cycles. `tick` width is exactly 1 cycle.
- Ping-pong, N=1, LED_W=8 -> `pos` sequence 1,2,…,7,6,5,…,0,1. `dir` toggles on the edges to 6 and to 1. `led` is always one-hot matching `pos`.
- Pause: N=10, drop `count_en` at `cnt`=6 for 20 cycles, then re-raise -> no tick during the pause. `pos`/`led` held. Next tick 10 enabled edges after re-enable.
- Period change mid-count: N=100 at `cnt`=50, switch to 20 -> no tick on the change edge. Next tick 20 edges after it. `pos` unchanged across the change.
- `tm_value`=0 with `count_en`=1 -> `tick` never asserts. `cnt` stays 0. Pattern frozen.
